dsm_select_gen: RTL and testbench
=================================

// Module: dsm_select_gen
// PURPOSE
//  First-order single-bit delta-sigma modulator producing select_mode for the 240/248 frequency divider.
//  Clocked by the divider output (PFD reference rate), so it issues one modulus decision per divider cycle.
//  Average division = 248 - 8*frac/2^ACC_W. frac words are loaded over a valid/ready handshake and applied glitch-free.
// PARAMETERS
//  ACC_W    16   accumulator / fractional word width
//  LFSR_W   15   dither LFSR width (used only with DSM_DITHER_EN)
// PORTS
//  clk          in   1       divider output clock (freq_out)
//  rst          in   1       asynchronous, active-low reset
//  en           in   1       1 = modulate, 0 = hold integer div-248
//  frac_in      in   ACC_W   fractional control word
//  frac_valid   in   1       frac_in valid
//  frac_ready   out  1       shadow register empty, transfer accepted
//  select_mode  out  1       1 = div-240, 0 = div-248 (to divider)
//  running      out  1       FSM in RUN
// BEHAVIOUR
//  Reset (rst=0, async): acc=0, frac_reg=0, shadow empty, select_mode=0, frac_ready=1, running=0, FSM=IDLE.
//  Reset mid-operation: all of the above take effect immediately, without waiting for a clk edge.
//  Handshake: transfer on the clk edge with frac_valid & frac_ready, frac_in -> shadow, shadow_full<=1.
//   frac_ready = ~shadow_full (registered state, no comb path from frac_valid).
//   frac_ready is never high while shadow_full, so a capture and a promotion never collide.
//  Promotion shadow->frac_reg (shadow_full<=0 on the same edge):
//   IDLE: on the first edge with shadow_full.
//   RUN: on an edge where the computed carry=1, or where frac_reg==0.
//   The new word is used from the following edge, so the rate changes only at a carry boundary.
//  FSM:
//   IDLE: acc held at 0, select_mode=0. Any edge with en=1 -> RUN with acc<=0.
//   RUN: each edge {carry,acc} <= acc + frac_reg + cin (ACC_W+1-bit add, acc wraps mod 2^ACC_W).
//    select_mode <= carry, i.e. registered with 1 edge of latency from the sum.
//    An edge with en=0 -> IDLE, acc<=0, select_mode<=0 on that same edge.
//  running = (FSM==RUN).
//  Boundaries:
//   frac_reg=0: select_mode stays 0 forever.
//   frac_reg=2^ACC_W-1: select_mode=1 on all but 1 of every 2^ACC_W edges (cin=0).
//   Exactly frac_reg ones per 2^ACC_W RUN edges when cin=0.
// CONFIGURATION
//  DSM_DITHER_EN defined: LFSR_W-bit Fibonacci LFSR, x^15+x^14+1, reset seed 1.
//   The LFSR advances only in RUN. cin = lfsr[0]; the LFSR holds in IDLE.
//  DSM_DITHER_EN undefined: cin=0, no LFSR logic; output is fully deterministic.
// TESTING
//  1. en=1, frac=0x8000, no dither -> select_mode 0,1,0,1,... from the first RUN edge; 512 ones in 1024 edges.
//  2. frac=0x4000 -> pattern 0,0,0,1 repeating; exactly 256 ones in 1024 edges; running=1.
//  3. frac=0x0000 for 1000 edges -> select_mode=0 throughout; then en=0 -> running=0 on the next edge, select_mode=0.
//  4. In RUN at frac=0x4000, load 0x8000 -> frac_ready=0 until the carry edge, then 1.
//     The 0,1 alternation starts on the edge after the carry.
//  5. Drive rst=0 mid-RUN between edges -> select_mode=0 and frac_ready=1 immediately.
//     After release with en=1 -> restart from acc=0 with frac_reg=0.
//  6. DSM_DITHER_EN, frac=0x8000 over 65536 edges -> ones count within 32768 +/- 1; pattern not period-2.

Source files
------------

// File: rtl/dsm_select_gen.sv
// rtl/dsm_select_gen.sv - first-order 1-bit delta-sigma modulus selector for the 240/248 divider
// Optional carry-in dither LFSR enabled by defining DSM_DITHER_EN.
module dsm_select_gen #(
  parameter int ACC_W = 16
`ifdef DSM_DITHER_EN
  , parameter int LFSR_W = 15
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] frac_in,
  input  logic             frac_valid,
  output logic             frac_ready,
  output logic             select_mode,
  output logic             running
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] frac_reg;
  logic [ACC_W-1:0] shadow;
  logic             shadow_full;
  logic             cin;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             promote;
  logic             capture;

  assign sum   = {1'b0, acc} + {1'b0, frac_reg} + {{ACC_W{1'b0}}, cin};
  assign carry = sum[ACC_W];

  // Swapping the word only at a carry keeps the output rate change glitch-free;
  // a zero word never carries, so it must be replaceable on any edge.
  assign promote = shadow_full && ((state == IDLE) || carry || (frac_reg == '0));
  assign capture = frac_valid && frac_ready;

  assign frac_ready = ~shadow_full;
  assign running    = (state == RUN);

`ifdef DSM_DITHER_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= {{(LFSR_W-1){1'b0}}, 1'b1};
    end else if (state == RUN) begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
    end
  end

  assign cin = lfsr[0];
`else
  assign cin = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= '0;
      frac_reg    <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      select_mode <= 1'b0;
    end else begin
      if (promote) begin
        frac_reg <= shadow;
      end

      if (capture) begin
        shadow      <= frac_in;
        shadow_full <= 1'b1;
      end else if (promote) begin
        shadow_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          acc         <= '0;
          select_mode <= 1'b0;
          if (en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            acc         <= sum[ACC_W-1:0];
            select_mode <= carry;
          end else begin
            state       <= IDLE;
            acc         <= '0;
            select_mode <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= '0;
          select_mode <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsm_select_gen.sv
// tb/tb_dsm_select_gen.sv - randomized and directed self-checking bench for dsm_select_gen
module tb_dsm_select_gen;

  localparam int ACC_W = 16;
  localparam int MOD   = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [ACC_W-1:0] frac_in = '0;
  logic             frac_valid = 1'b0;
  logic             frac_ready;
  logic             select_mode;
  logic             running;

  dsm_select_gen #(.ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frac_in    (frac_in),
    .frac_valid (frac_valid),
    .frac_ready (frac_ready),
    .select_mode(select_mode),
    .running    (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference: integer phase accumulator plus a one-deep pending-word slot
  int   m_acc;
  int   m_f;
  int   m_sh;
  logic m_full;
  logic m_run;
  logic m_sel;
  logic m_cap;
  logic model_on = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_f = 0; m_sh = 0; m_full = 1'b0; m_run = 1'b0; m_sel = 1'b0; m_cap = 1'b0;
  endtask

  // predict one clock edge from the current inputs, then compare after it
  task automatic step();
    logic cap;
    logic prom;
    logic c;
    int   total;
    cap  = frac_valid && !m_full;
    prom = 1'b0;
    if (!m_run) begin
      prom  = m_full;
      m_acc = 0;
      m_sel = 1'b0;
      m_run = en;
    end else begin
      total = m_acc + m_f;
      c     = (total >= MOD);
      prom  = m_full && (c || m_f == 0);
      if (en) begin
        m_acc = total % MOD;
        m_sel = c;
      end else begin
        m_run = 1'b0;
        m_acc = 0;
        m_sel = 1'b0;
      end
    end
    if (prom) begin
      m_f    = m_sh;
      m_full = 1'b0;
    end
    if (cap) begin
      m_sh   = int'(frac_in);
      m_full = 1'b1;
    end
    m_cap = cap;
    @(posedge clk);
    @(negedge clk);
    if (model_on) begin
      check("select_mode", select_mode, m_sel);
      check("frac_ready", frac_ready, !m_full);
      check("running", running, m_run);
    end
  endtask

  task automatic load(input logic [ACC_W-1:0] w);
    frac_in    = w;
    frac_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (m_cap) break;
    end
    frac_valid = 1'b0;
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (select_mode === 1'b1) ones++;
    end
  endtask

  initial begin
    int ones;
    int guard;
    model_reset();
    #1;
    check("reset_select_mode", select_mode, 1'b0);
    check("reset_frac_ready", frac_ready, 1'b1);
    check("reset_running", running, 1'b0);
    @(negedge clk);
    rst = 1'b1;

`ifdef DSM_DITHER_EN
    begin
      logic prev;
      logic not_period2;
      model_on = 1'b0;
      load(16'h8000);
      en = 1'b1;
      step();
      ones        = 0;
      not_period2 = 1'b0;
      prev        = select_mode;
      for (int i = 0; i < 65536; i++) begin
        step();
        if (select_mode === 1'b1) ones++;
        if (i > 0 && select_mode === prev) not_period2 = 1'b1;
        prev = select_mode;
      end
      check("dither_ones_in_range", (ones >= 32767 && ones <= 32769), 1'b1);
      check("dither_not_period2", not_period2, 1'b1);
    end
`else
    // half-rate word: strict 0,1 alternation
    load(16'h8000);
    en = 1'b1;
    step();
    count_ones(1024, ones);
    check("ones_0x8000", ones, 512);

    // quarter-rate word: 0,0,0,1
    en = 1'b0;
    step();
    load(16'h4000);
    en = 1'b1;
    step();
    count_ones(1024, ones);
    check("ones_0x4000", ones, 256);
    check("running_0x4000", running, 1'b1);

    // zero word never selects div-240
    en = 1'b0;
    step();
    load(16'h0000);
    en = 1'b1;
    step();
    count_ones(1000, ones);
    check("ones_0x0000", ones, 0);
    en = 1'b0;
    step();
    check("stop_running", running, 1'b0);
    check("stop_select", select_mode, 1'b0);

    // word change while running waits for a carry edge
    load(16'h4000);
    en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    load(16'h8000);
    for (int i = 0; i < 12; i++) step();

    // capture a word on a carry edge so select_mode=1 and frac_ready=0 before async reset
    guard = 0;
    while (m_acc + m_f < MOD && guard < 16) begin
      step();
      guard++;
    end
    check("carry_found", guard < 16, 1'b1);
    frac_in    = 16'h1234;
    frac_valid = 1'b1;
    step();
    frac_valid = 1'b0;
    check("pre_reset_select", select_mode, 1'b1);
    check("pre_reset_ready", frac_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async_select_mode", select_mode, 1'b0);
    check("async_frac_ready", frac_ready, 1'b1);
    check("async_running", running, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    count_ones(20, ones);
    check("post_reset_ones", ones, 0);
    check("post_reset_running", running, 1'b1);

    // random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      en         = ($urandom_range(0, 15) != 0);
      frac_valid = ($urandom_range(0, 3) == 0);
      frac_in    = ACC_W'($urandom);
      step();
    end
    frac_valid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
